// File: rtl/data_memory_pipe.sv
// data_memory_pipe: single-port synchronous data memory with valid/ready handshake, byte enables, LATENCY-cycle response; DMEM_ERR_CHECK_EN adds address error checking
module data_memory_pipe #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);
    localparam int NB  = DATA_W / 8;
    localparam int OFS = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t              state;
    logic [1:0]          cnt;
    logic                wr_q;
    logic                err_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [IW-1:0]       idx;
    logic                err;
    logic                accept;
    assign idx       = req_addr[OFS +: IW];
    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready && !rst;
`ifdef DMEM_ERR_CHECK_EN
    assign err = ((req_addr & ADDR_W'(NB - 1)) != '0) || ((req_addr >> (OFS + IW)) != '0);
`else
    logic unused_addr;
    assign unused_addr = ^req_addr;
    assign err = 1'b0;
`endif
    // array and request capture are kept free of reset so the array maps to RAM
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q  <= req_write;
            err_q <= err;
            if (req_write) begin
                if (!err)
                    for (int i = 0; i < NB; i++)
                        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end else begin
                data_q <= err ? '0 : mem[idx];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (state == IDLE) begin
                if (req_valid) begin
                    state <= BUSY;
                    cnt   <= 2'(LATENCY - 1);
                end
            end else if (cnt == '0) begin
                state     <= IDLE;
                rsp_valid <= 1'b1;
                rsp_err   <= err_q;
                if (!wr_q) rsp_rdata <= data_q;
            end else begin
                cnt <= cnt - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: directed self-checking bench for data_memory_pipe with LATENCY=2
module tb_data_memory_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_pipe #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] rd, output logic er,
                          output int lat, output logic tail);
        int g = 0;
        req_write = w; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
        while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 99; rd = '0; er = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin lat = i; rd = rsp_rdata; er = rsp_err; break; end
        end
        @(posedge clk); #1;
        tail = rsp_valid;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", rsp_err); end
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        logic [31:0] rd; logic er, tail; int lat;
        do_req(1'b1, 32'h0, 32'h19283746, 4'hF, rd, er, lat, tail);
        checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency got %0d exp 2", lat); end
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, tail);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency got %0d exp 2", lat); end
        checks++; if (rd !== 32'h19283746) begin errors++; $display("FAIL rd_data got %h exp 19283746", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", er); end
        checks++; if (tail !== 1'b0) begin errors++; $display("FAIL rsp_pulse_width got %b exp 0", tail); end
    endtask

    task automatic test_byte_enable;
        logic [31:0] rd; logic er, tail; int lat;
        do_req(1'b1, 32'h0, 32'hAABBCCDD, 4'h5, rd, er, lat, tail);
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, tail);
        checks++; if (rd !== 32'h19BB37DD) begin errors++; $display("FAIL be5_data got %h exp 19bb37dd", rd); end
        do_req(1'b1, 32'h0, 32'h55555555, 4'h0, rd, er, lat, tail);
        checks++; if (lat !== 2) begin errors++; $display("FAIL be0_ack_latency got %0d exp 2", lat); end
        checks++; if (rd !== 32'h19BB37DD) begin errors++; $display("FAIL be0_rdata_hold got %h exp 19bb37dd", rd); end
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, tail);
        checks++; if (rd !== 32'h19BB37DD) begin errors++; $display("FAIL be0_data got %h exp 19bb37dd", rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic er, tail; int lat;
        logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
        logic [31:0] exp_d [3] = '{32'h19BB37DD, 32'h44444444, 32'h88888888};
        int acc [3]; int rsp [3]; logic [31:0] dat [3];
        int na = 0, nr = 0, busy = 0, cyc = 0;
        logic ready_pre;
        do_req(1'b1, 32'h4, 32'h44444444, 4'hF, rd, er, lat, tail);
        do_req(1'b1, 32'h8, 32'h88888888, 4'hF, rd, er, lat, tail);
        req_write = 1'b0; req_addr = addrs[0]; req_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            ready_pre = req_ready;
            @(posedge clk); #1;
            cyc++;
            if (ready_pre && req_valid) begin
                acc[na] = cyc; na++;
                if (na < 3) req_addr = addrs[na]; else req_valid = 1'b0;
            end
            if (!req_ready) busy++;
            if (rsp_valid) begin
                if (nr < 3) begin rsp[nr] = cyc; dat[nr] = rsp_rdata; end
                nr++;
            end
        end
        req_valid = 1'b0;
        checks++; if (na !== 3 || nr !== 3) begin errors++; $display("FAIL b2b_counts got acc=%0d rsp=%0d exp 3 3", na, nr); end
        checks++; if (busy !== 6) begin errors++; $display("FAIL b2b_busy_cycles got %0d exp 6", busy); end
        if (na == 3 && nr == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (rsp[i] !== acc[i] + 2) begin errors++; $display("FAIL b2b_rsp_time[%0d] got %0d exp %0d", i, rsp[i], acc[i] + 2); end
                checks++; if (dat[i] !== exp_d[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, dat[i], exp_d[i]); end
            end
            checks++; if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3) begin errors++; $display("FAIL b2b_spacing got %0d %0d exp 3 3", acc[1] - acc[0], acc[2] - acc[1]); end
        end
    endtask

    task automatic test_reset_midop;
        logic [31:0] rd; logic er, tail; int lat; int seen = 0;
        req_write = 1'b0; req_addr = 32'h0; req_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; req_write = 1'b1; req_wdata = 32'hDEADBEEF; req_be = 4'hF;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b exp 1", req_ready); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata got %h exp 0", rsp_rdata); end
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_rsp_valid got %0d pulses exp 0", seen); end
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, tail);
        checks++; if (rd !== 32'h19BB37DD) begin errors++; $display("FAIL midrst_readback got %h exp 19bb37dd", rd); end
    endtask

    task automatic test_addr_error;
        logic [31:0] rd; logic er, tail; int lat;
        do_req(1'b0, 32'h400, 32'h0, 4'h0, rd, er, lat, tail);
`ifdef DMEM_ERR_CHECK_EN
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h exp 0", rd); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_err got %b exp 1", er); end
        do_req(1'b1, 32'h2, 32'h12345678, 4'hF, rd, er, lat, tail);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_err got %b exp 1", er); end
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, tail);
        checks++; if (rd !== 32'h19BB37DD) begin errors++; $display("FAIL misalign_unchanged got %h exp 19bb37dd", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL aligned_err got %b exp 0", er); end
`else
        checks++; if (rd !== 32'h19BB37DD) begin errors++; $display("FAIL wrap_rdata got %h exp 19bb37dd", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wrap_err got %b exp 0", er); end
`endif
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_byte_enable;
        test_back_to_back;
        test_reset_midop;
        test_addr_error;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_pipe.md
Name: data_memory_pipe

Overview:
Parametrised, clocked data memory for the MEM stage of the pipelined core. It replaces the combinational read/write data memory with a single-port synchronous array. Features:
- valid/ready request handshake
- byte-lane write enables
- configurable response latency
- registered read data and write acknowledge

The LSU issues one request at a time and stalls the pipeline on req_ready.

Parameters:
DATA_W, 32, word width in bits; multiple of 8.
ADDR_W, 32, byte-address width.
DEPTH, 256, number of words; power of two.
LATENCY, 1, cycles from accept edge to response edge; legal 1..4.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  write data.
req_be  in  DATA_W/8  byte-lane write enables; bit i enables bits [8i+7:8i].
rsp_valid  out  1  one-cycle response strobe (read data or write ack).
rsp_rdata  out  DATA_W  read data.
rsp_err  out  1  access error, qualified by rsp_valid.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, internal counter 0.
- Array contents are not cleared by reset.
- Word index: req_addr[OFS +: log2(DEPTH)], where OFS = log2(DATA_W/8). The low OFS bits are the byte offset.
- FSM states: IDLE, BUSY. req_ready = (state==IDLE), purely from registered state.
- Accept: req_valid && req_ready at a rising edge (edge N). At edge N:
  - Write: each byte lane with req_be[i]=1 is written into the array. Lanes with req_be[i]=0 are unchanged. req_be=0 writes nothing but is still acknowledged.
  - Read: the array word at the index is captured into an internal data register. This is the value before any write; only one request is in flight at a time.
  - The request type is captured. State goes to BUSY and cnt is loaded with LATENCY-1.
- In BUSY, at each edge:
  - If cnt==0: state goes to IDLE and rsp_valid is set to 1 for exactly one cycle.
    - For a read, rsp_rdata is loaded from the data register.
    - For a write, rsp_rdata keeps its previous value.
  - Otherwise cnt decrements.
- Timing: the response is visible in the cycle after edge N+LATENCY. req_ready is 1 in that same cycle, so the earliest next accept is edge N+LATENCY+1. Maximum throughput is one request per LATENCY+1 cycles.
- req_valid while req_ready=0 is ignored, with no side effects. The requester holds the request until accepted.
- rsp_rdata holds its value between read responses. rsp_err is valid only with rsp_valid and is 0 otherwise.
- Reset mid-operation: an in-flight request is abandoned and no rsp_valid is produced. A request presented on a reset edge is not accepted and its write is not performed. Writes completed before reset persist.
- Out-of-range addresses and a nonzero byte offset: see Optional Feature.

Optional Feature:
Macro DMEM_ERR_CHECK_EN.

Defined:
- An access is an error if the byte offset is nonzero (misaligned), or if the upper address bits above the index are nonzero (address >= DEPTH*DATA_W/8).
- An erroring write modifies nothing.
- An erroring read returns rsp_rdata=0.
- Both complete normally with rsp_err=1 after LATENCY.

Not defined:
- rsp_err is tied to 0.
- The byte offset is ignored.
- The index wraps modulo DEPTH, with the upper bits discarded.

Test Plan:
1. DATA_W=32, DEPTH=256, LATENCY=2. After reset, write 0x19283746 to addr 0x0 with be=0xF, then read 0x0 -> read rsp_valid exactly 2 edges after its accept edge, rsp_rdata=0x19283746, rsp_err=0.
2. Write 0xAABBCCDD to 0x0 with be=0x5 over case 1, then read 0x0 -> rsp_rdata=0x19BB37DD. A write with be=0x0 to 0x0 -> ack received, data unchanged.
3. Hold req_valid=1 continuously with reads of 0x0, 0x4, 0x8 -> req_ready low in each BUSY cycle, accepts exactly 3 cycles apart, three rsp_valid pulses each one cycle wide.
4. Accept a read of 0x0, assert rst on the following edge -> no rsp_valid, req_ready=1 after reset, rsp_rdata=0. A subsequent read of 0x0 returns 0x19BB37DD.
5. Without the macro: read 0x400 -> returns word 0 contents, rsp_err=0. With DMEM_ERR_CHECK_EN: read 0x400 -> rsp_rdata=0, rsp_err=1. Write 0x12345678 to 0x2 -> rsp_err=1, and word 0 is unchanged on readback.
